// File: rtl/mcu_command_decoder_pkg.sv
// rtl/mcu_command_decoder_pkg.sv - msgpu opcodes and decoder state encoding
package mcu_command_decoder_pkg;

  localparam logic [7:0] CMD_SET_ADDRESS  = 8'h01;
  localparam logic [7:0] CMD_WRITE_PIXELS = 8'h02;
  localparam logic [7:0] CMD_FILL         = 8'h03;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR0,
    ST_ADDR1,
    ST_ADDR2,
    ST_CNT_HI,
    ST_CNT_LO,
    ST_PIXELS,
    ST_FILL_COLOUR,
    ST_FILL
  } state_t;

endpackage

// File: rtl/mcu_command_decoder_if.sv
// rtl/mcu_command_decoder_if.sv - byte stream in, framebuffer write requests out
interface mcu_command_decoder_if #(
  parameter int ADDR_WIDTH = 22,
  parameter int DATA_WIDTH = 8
) ();

  logic                  byte_valid;
  logic [DATA_WIDTH-1:0] byte_data;
  logic                  byte_is_command;

  logic                  wr_valid;
  logic [ADDR_WIDTH-1:0] wr_address;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_ready;

  modport master (
    output byte_valid, byte_data, byte_is_command, wr_ready,
    input  wr_valid, wr_address, wr_data
  );

  modport slave (
    input  byte_valid, byte_data, byte_is_command, wr_ready,
    output wr_valid, wr_address, wr_data
  );

endinterface

// File: rtl/mcu_byte_fifo.sv
// rtl/mcu_byte_fifo.sv - synchronous input byte FIFO, DEPTH a power of two
module mcu_byte_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic             system_clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] dout
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge system_clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge system_clock) begin
    if (push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/mcu_command_decoder.sv
// rtl/mcu_command_decoder.sv - parses the msgpu command byte stream into framebuffer writes
module mcu_command_decoder
  import mcu_command_decoder_pkg::*;
#(
  parameter int ADDR_WIDTH = 22,
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 system_clock,
  input  logic                 reset,
  mcu_command_decoder_if.slave bus,
  output logic                 busy,
  output logic                 error,
  output logic                 overflow
);

  localparam int CNT_WIDTH   = 2 * DATA_WIDTH;
  localparam int ENTRY_WIDTH = DATA_WIDTH + 1;

  state_t                state, state_n;
  logic [ADDR_WIDTH-1:0] ptr, ptr_n;
  logic [CNT_WIDTH-1:0]  count, count_n;
  logic [DATA_WIDTH-1:0] addr_hi, addr_hi_n;
  logic [DATA_WIDTH-1:0] addr_mid, addr_mid_n;
  logic [DATA_WIDTH-1:0] cnt_hi, cnt_hi_n;
  logic [DATA_WIDTH-1:0] colour, colour_n;
  logic                  fill_mode, fill_mode_n;
  logic                  error_n;

  logic                  push, pop, issue;
  logic [DATA_WIDTH-1:0] issue_data;
  logic                  fifo_full, fifo_empty;
  logic [ENTRY_WIDTH-1:0] fifo_dout;
  logic                  head_cmd;
  logic [DATA_WIDTH-1:0] head_byte;
  logic                  slot_free;

  logic                  wr_valid_q;
  logic [ADDR_WIDTH-1:0] wr_address_q;
  logic [DATA_WIDTH-1:0] wr_data_q;

  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign push = bus.byte_valid && (!fifo_full || pop);

  mcu_byte_fifo #(
    .WIDTH (ENTRY_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .system_clock (system_clock),
    .reset        (reset),
    .push         (push),
    .pop          (pop),
    .din          ({bus.byte_is_command, bus.byte_data}),
    .full         (fifo_full),
    .empty        (fifo_empty),
    .dout         (fifo_dout)
  );

  assign head_cmd  = fifo_dout[DATA_WIDTH];
  assign head_byte = fifo_dout[DATA_WIDTH-1:0];
  assign slot_free = !wr_valid_q || bus.wr_ready;

  always_ff @(posedge system_clock or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n     = state;
    ptr_n       = ptr;
    count_n     = count;
    addr_hi_n   = addr_hi;
    addr_mid_n  = addr_mid;
    cnt_hi_n    = cnt_hi;
    colour_n    = colour;
    fill_mode_n = fill_mode;
    error_n     = error;
    pop         = 1'b0;
    issue       = 1'b0;
    issue_data  = '0;

    if (state == ST_FILL) begin
      // FILL ignores the FIFO entirely; bytes arriving now wait until it ends.
      if (slot_free) begin
        issue      = 1'b1;
        issue_data = colour;
        ptr_n      = ptr + ADDR_WIDTH'(1);
        count_n    = count - CNT_WIDTH'(1);
        if (count == CNT_WIDTH'(1)) state_n = ST_IDLE;
      end
    end else if (!fifo_empty) begin
      if (head_cmd) begin
        pop = 1'b1;
        if (head_byte == DATA_WIDTH'(CMD_SET_ADDRESS)) begin
          state_n = ST_ADDR0;
        end else if (head_byte == DATA_WIDTH'(CMD_WRITE_PIXELS)) begin
          state_n     = ST_CNT_HI;
          fill_mode_n = 1'b0;
        end else if (head_byte == DATA_WIDTH'(CMD_FILL)) begin
          state_n     = ST_CNT_HI;
          fill_mode_n = 1'b1;
        end else begin
          state_n = ST_IDLE;
          error_n = 1'b1;
        end
      end else begin
        case (state)
          ST_IDLE: begin
            pop     = 1'b1;
            error_n = 1'b1;
          end
          ST_ADDR0: begin
            pop       = 1'b1;
            addr_hi_n = head_byte;
            state_n   = ST_ADDR1;
          end
          ST_ADDR1: begin
            pop        = 1'b1;
            addr_mid_n = head_byte;
            state_n    = ST_ADDR2;
          end
          ST_ADDR2: begin
            pop     = 1'b1;
            ptr_n   = ADDR_WIDTH'({addr_hi, addr_mid, head_byte});
            state_n = ST_IDLE;
          end
          ST_CNT_HI: begin
            pop      = 1'b1;
            cnt_hi_n = head_byte;
            state_n  = ST_CNT_LO;
          end
          ST_CNT_LO: begin
            pop     = 1'b1;
            count_n = {cnt_hi, head_byte};
            if (fill_mode)              state_n = ST_FILL_COLOUR;
            else if (count_n == '0)     state_n = ST_IDLE;
            else                        state_n = ST_PIXELS;
          end
          ST_FILL_COLOUR: begin
            pop      = 1'b1;
            colour_n = head_byte;
            state_n  = (count == '0) ? ST_IDLE : ST_FILL;
          end
          ST_PIXELS: begin
            if (slot_free) begin
              pop        = 1'b1;
              issue      = 1'b1;
              issue_data = head_byte;
              ptr_n      = ptr + ADDR_WIDTH'(1);
              count_n    = count - CNT_WIDTH'(1);
              if (count == CNT_WIDTH'(1)) state_n = ST_IDLE;
            end
          end
          default: state_n = ST_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge system_clock or negedge reset) begin
    if (!reset) begin
      ptr       <= '0;
      count     <= '0;
      addr_hi   <= '0;
      addr_mid  <= '0;
      cnt_hi    <= '0;
      colour    <= '0;
      fill_mode <= 1'b0;
      error     <= 1'b0;
    end else begin
      ptr       <= ptr_n;
      count     <= count_n;
      addr_hi   <= addr_hi_n;
      addr_mid  <= addr_mid_n;
      cnt_hi    <= cnt_hi_n;
      colour    <= colour_n;
      fill_mode <= fill_mode_n;
      error     <= error_n;
    end
  end

  always_ff @(posedge system_clock or negedge reset) begin
    if (!reset) begin
      wr_valid_q   <= 1'b0;
      wr_address_q <= '0;
      wr_data_q    <= '0;
    end else if (issue) begin
      wr_valid_q   <= 1'b1;
      wr_address_q <= ptr;
      wr_data_q    <= issue_data;
    end else if (bus.wr_ready) begin
      wr_valid_q   <= 1'b0;
    end
  end

  always_ff @(posedge system_clock or negedge reset) begin
    if (!reset)                                     overflow <= 1'b0;
    else if (bus.byte_valid && fifo_full && !pop)   overflow <= 1'b1;
  end

  assign bus.wr_valid   = wr_valid_q;
  assign bus.wr_address = wr_address_q;
  assign bus.wr_data    = wr_data_q;

  assign busy = !fifo_empty || (state != ST_IDLE) || wr_valid_q;

endmodule

// File: tb/tb_mcu_command_decoder.sv
// tb/tb_mcu_command_decoder.sv - randomized and directed bench for mcu_command_decoder
module tb_mcu_command_decoder;

  localparam int AW    = 22;
  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int ASPAN = 1 << AW;

  logic system_clock = 1'b0;
  logic reset;
  logic busy, error, overflow;

  mcu_command_decoder_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  mcu_command_decoder #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .system_clock (system_clock),
    .reset        (reset),
    .bus          (bus),
    .busy         (busy),
    .error        (error),
    .overflow     (overflow)
  );

  always #5 system_clock = ~system_clock;

  typedef struct {
    int a;
    int d;
  } wr_t;

  int  vectors = 0;
  int  miscompares = 0;
  int  accepted = 0;
  int  ready_mode = 0;
  wr_t exp_q[$];

  // Protocol-level model: position of each data byte within its command decides its meaning.
  int  m_op, m_k, m_ptr, m_b0, m_b1, m_n;
  bit  exp_error;

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic model_reset();
    m_op = 0; m_k = 0; m_ptr = 0; m_b0 = 0; m_b1 = 0; m_n = 0;
    exp_error = 1'b0;
    exp_q.delete();
  endtask

  task automatic model_byte(input bit is_cmd, input logic [7:0] v);
    if (is_cmd) begin
      m_k  = 0;
      m_op = int'(v);
      if (!(m_op inside {1, 2, 3})) begin
        exp_error = 1'b1;
        m_op = 0;
      end
      return;
    end
    case (m_op)
      1: begin
        if (m_k == 0)      m_b0 = int'(v);
        else if (m_k == 1) m_b1 = int'(v);
        else if (m_k == 2) m_ptr = ((m_b0 * 65536) + (m_b1 * 256) + int'(v)) % ASPAN;
        else               exp_error = 1'b1;
      end
      2: begin
        if (m_k == 0)               m_b0 = int'(v);
        else if (m_k == 1)          m_n = m_b0 * 256 + int'(v);
        else if (m_k - 2 < m_n) begin
          exp_q.push_back('{a: m_ptr, d: int'(v)});
          m_ptr = (m_ptr + 1) % ASPAN;
        end else                    exp_error = 1'b1;
      end
      3: begin
        if (m_k == 0)      m_b0 = int'(v);
        else if (m_k == 1) m_n = m_b0 * 256 + int'(v);
        else if (m_k == 2) begin
          for (int i = 0; i < m_n; i++) begin
            exp_q.push_back('{a: m_ptr, d: int'(v)});
            m_ptr = (m_ptr + 1) % ASPAN;
          end
        end else           exp_error = 1'b1;
      end
      default: exp_error = 1'b1;
    endcase
    m_k++;
  endtask

  task automatic tick();
    @(posedge system_clock);
    #1;
  endtask

  task automatic wait_room();
    int c = 0;
    while (exp_q.size() > 1 && c < 1000) begin
      tick();
      c++;
    end
    if (c >= 1000) check("pace_timeout", exp_q.size(), 1);
  endtask

  task automatic send(input bit is_cmd, input logic [7:0] v, input bit use_model, input bit pace);
    if (pace) wait_room();
    bus.byte_valid      = 1'b1;
    bus.byte_is_command = is_cmd;
    bus.byte_data       = v;
    if (use_model) model_byte(is_cmd, v);
    tick();
    bus.byte_valid = 1'b0;
  endtask

  task automatic cmd(input logic [7:0] v);
    send(1'b1, v, 1'b1, 1'b1);
  endtask

  task automatic dat(input logic [7:0] v);
    send(1'b0, v, 1'b1, 1'b1);
  endtask

  task automatic wait_idle(input string tag);
    int c = 0;
    while ((busy !== 1'b0 || exp_q.size() != 0) && c < 3000) begin
      tick();
      c++;
    end
    check({tag, "_drained"}, exp_q.size(), 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    bus.byte_valid = 1'b0;
    model_reset();
    repeat (2) tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic scenario_basic(input string tag);
    int acc0;
    ready_mode = 0;
    acc0 = accepted;
    cmd(8'h01); dat(8'h12); dat(8'h34); dat(8'h56);
    cmd(8'h02); dat(8'h00); dat(8'h03);
    repeat (3) tick();
    dat(8'hAA);
    check({tag, "_lat_t1"}, bus.wr_valid, 0);
    tick();
    check({tag, "_lat_t2"}, bus.wr_valid, 1);
    dat(8'hBB); dat(8'hCC);
    wait_idle(tag);
    check({tag, "_writes"}, accepted - acc0, 3);
    check({tag, "_error"}, error, exp_error);
  endtask

  // Write-side scoreboard: any presented request must match the head of the expected list.
  always @(negedge system_clock) begin
    if (reset === 1'b1 && bus.wr_valid === 1'b1) begin
      check("wr_expected", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        check("wr_address", 32'(bus.wr_address), exp_q[0].a);
        check("wr_data", 32'(bus.wr_data), exp_q[0].d);
        if (bus.wr_ready === 1'b1) begin
          void'(exp_q.pop_front());
          accepted++;
        end
      end
    end
  end

  initial begin
    bus.wr_ready = 1'b1;
    forever begin
      @(posedge system_clock);
      #1;
      case (ready_mode)
        0:       bus.wr_ready = 1'b1;
        1:       bus.wr_ready = 1'b0;
        default: bus.wr_ready = ($urandom_range(0, 9) < 6);
      endcase
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int acc0, r, n, sent;
    logic [31:0] addr;

    bus.byte_valid = 1'b0;
    bus.byte_data = '0;
    bus.byte_is_command = 1'b0;
    model_reset();
    reset = 1'b1;
    #1 reset = 1'b0;
    tick();
    check("rst_wr_valid", bus.wr_valid, 0);
    check("rst_wr_address", 32'(bus.wr_address), 0);
    check("rst_wr_data", 32'(bus.wr_data), 0);
    check("rst_busy", busy, 0);
    check("rst_error", error, 0);
    check("rst_overflow", overflow, 0);
    tick();
    reset = 1'b1;
    tick();

    // Basic write
    scenario_basic("t1");

    // Backpressure with overflow
    apply_reset();
    ready_mode = 1;
    cmd(8'h02); dat(8'h00); dat(8'h06);
    repeat (3) tick();
    acc0 = accepted;
    for (int i = 0; i < 6; i++) send(1'b0, 8'hA0 + 8'(i), i < 5, 1'b0);
    repeat (3) tick();
    check("t2_overflow", overflow, 1);
    check("t2_stall_valid", bus.wr_valid, 1);
    check("t2_stall_data", 32'(bus.wr_data), 32'hA0);
    ready_mode = 0;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin tick(); n++; end
    repeat (5) tick();
    check("t2_writes", accepted - acc0, 5);
    check("t2_busy_pixels", busy, 1);
    check("t2_error", error, 0);

    // Address wrap
    apply_reset();
    cmd(8'h01); dat(8'h3F); dat(8'hFF); dat(8'hFF);
    cmd(8'h02); dat(8'h00); dat(8'h02); dat(8'h11); dat(8'h22);
    wait_idle("t3");
    check("t3_error", error, 0);

    // Fill with a stray byte arriving mid-fill
    apply_reset();
    acc0 = accepted;
    cmd(8'h01); dat(8'h00); dat(8'h01); dat(8'h00);
    cmd(8'h03); dat(8'h00); dat(8'h05); dat(8'h1F);
    send(1'b0, 8'h44, 1'b1, 1'b0);
    check("t4_err_during_fill", error, 0);
    wait_idle("t4");
    check("t4_writes", accepted - acc0, 5);
    check("t4_error", error, 1);

    // Abort and unknown opcode
    apply_reset();
    acc0 = accepted;
    cmd(8'h02); dat(8'h00); dat(8'h04); dat(8'h01); dat(8'h02);
    cmd(8'h01); dat(8'h00); dat(8'h00); dat(8'h10);
    cmd(8'h02); dat(8'h00); dat(8'h01); dat(8'h55);
    wait_idle("t5a");
    check("t5_writes", accepted - acc0, 3);
    check("t5_error_before", error, 0);
    cmd(8'h7E);
    wait_idle("t5b");
    check("t5_error_after", error, 1);
    check("t5_no_extra", accepted - acc0, 3);

    // Reset mid-operation
    apply_reset();
    ready_mode = 1;
    cmd(8'h02); dat(8'h00); dat(8'h0A);
    repeat (3) tick();
    for (int i = 0; i < 4; i++) send(1'b0, 8'h60 + 8'(i), 1'b1, 1'b0);
    check("t6_pre_valid", bus.wr_valid, 1);
    #2 reset = 1'b0;
    #1;
    check("t6_valid_async", bus.wr_valid, 0);
    check("t6_busy", busy, 0);
    check("t6_overflow", overflow, 0);
    model_reset();
    tick();
    reset = 1'b1;
    tick();
    scenario_basic("t6");

    // Randomized command stream with random backpressure
    apply_reset();
    ready_mode = 2;
    for (int it = 0; it < 80; it++) begin
      r = $urandom_range(0, 9);
      if (r <= 2) begin
        addr = $urandom;
        if ($urandom_range(0, 3) == 0) addr = 32'h003FFFFF - 32'($urandom_range(0, 3));
        cmd(8'h01); dat(addr[23:16]); dat(addr[15:8]); dat(addr[7:0]);
      end else if (r <= 5) begin
        n = $urandom_range(0, 6);
        sent = ($urandom_range(0, 4) == 0) ? $urandom_range(0, n) : n;
        cmd(8'h02); dat(8'h00); dat(8'(n));
        for (int p = 0; p < sent; p++) dat(8'($urandom));
      end else if (r <= 7) begin
        n = $urandom_range(0, 5);
        cmd(8'h03); dat(8'h00); dat(8'(n)); dat(8'($urandom));
      end else if (r == 8) begin
        dat(8'($urandom));
      end else begin
        cmd(8'($urandom_range(4, 255)));
      end
    end
    cmd(8'h01); dat(8'h00); dat(8'h00); dat(8'h00);
    wait_idle("rnd");
    check("rnd_error", error, exp_error);
    check("rnd_overflow", overflow, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mcu_command_decoder.md
Name: mcu_command_decoder

Overview:
- Sits directly downstream of mcu_bus, in the system_clock domain.
- Consumes the byte stream mcu_bus produces: one byte per strobe, tagged command or data.
- Buffers bytes in a small FIFO, parses the msgpu command protocol, and issues framebuffer write requests (address + pixel) over a valid/ready handshake.
- Replaces the ad-hoc shift-register pattern match in the top level.

Parameters:
- ADDR_WIDTH, 22, framebuffer word address width; matches the VGA read_address.
- DATA_WIDTH, 8, pixel/byte width.
- FIFO_DEPTH, 4, input byte FIFO entries; power of two, minimum 2.

Ports:
- system_clock  input  1  sole clock; all state on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- byte_valid  input  1  single-cycle strobe: byte_data and byte_is_command are valid this cycle.
- byte_data  input  DATA_WIDTH  byte from mcu_bus data_out.
- byte_is_command  input  1  1 = command byte, 0 = data byte.
- wr_valid  output  1  write request pending.
- wr_address  output  ADDR_WIDTH  target framebuffer address.
- wr_data  output  DATA_WIDTH  pixel value.
- wr_ready  input  1  framebuffer accepts the request this cycle.
- busy  output  1  FIFO non-empty, or state != IDLE, or wr_valid.
- error  output  1  sticky: unknown opcode or stray data byte.
- overflow  output  1  sticky: byte dropped because the FIFO was full.

Behaviour:
- Reset (asynchronous, active-low):
  - wr_valid=0, wr_address=0, wr_data=0, error=0, overflow=0.
  - FIFO empty, internal address pointer=0, count=0, state=IDLE.
  - Reset mid-transfer drops the pending write immediately.
- FIFO:
  - Entry = {is_command, byte}.
  - byte_valid while full: byte dropped, overflow set.
  - Simultaneous push and pop while full is legal; no drop.
- Pop rule:
  - At most one pop per cycle.
  - A pixel byte pops only if the output slot is free (wr_valid=0, or wr_ready=1 this cycle).
  - Header bytes pop unconditionally.
  - No pops while in FILL.
- Output register:
  - wr_valid rises the cycle after the pixel pop.
  - wr_address/wr_data are held stable while wr_valid=1 and wr_ready=0.
  - Back-to-back writes sustain one per cycle.
- Latency: pixel byte strobe at cycle t gives wr_valid at t+2 when the FIFO is empty and wr_ready=1.
- Opcodes:
  - 0x01 SET_ADDRESS: 3 data bytes, big-endian; low ADDR_WIDTH bits become the pointer.
  - 0x02 WRITE_PIXELS: 2 data bytes count (big-endian), then count pixel bytes. Each pixel is written at the pointer, then the pointer increments.
  - 0x03 FILL: 2 count bytes, then 1 colour byte. Issues count writes of the colour at consecutive addresses with no further input.
- States: IDLE, ADDR0..ADDR2, CNT_HI, CNT_LO, PIXELS, FILL_COLOUR, FILL.
  - Count=0: return to IDLE after CNT_LO (WRITE_PIXELS) or FILL_COLOUR (FILL); no writes issued.
- Pointer arithmetic: increments modulo 2^ADDR_WIDTH; 2^ADDR_WIDTH-1 wraps to 0.
- Command byte popped in any state other than FILL:
  - Aborts the current command; remaining count is discarded.
  - A write already in the output register still completes.
  - Decoding of the new opcode starts immediately.
- Error conditions:
  - Unknown opcode: error set, state=IDLE.
  - Data byte popped in IDLE: discarded, error set.
- error and overflow clear only on reset.

Decomposition:
- Shared include msgpu_defines.vh:
  - Opcode constants CMD_SET_ADDRESS=8'h01, CMD_WRITE_PIXELS=8'h02, CMD_FILL=8'h03.
  - Decoder state encodings.
- Sub-module mcu_byte_fifo:
  - Synchronous FIFO, width DATA_WIDTH+1, depth FIFO_DEPTH.
  - Ports: push, pop, full, empty, dout.
  - Same clock and reset.

Test Plan:
1. Basic write: with wr_ready=1, send cmd 01, data 12 34 56; cmd 02, data 00 03 AA BB CC -> writes (0x123456,AA), (0x123457,BB), (0x123458,CC); busy falls after the last accept.
2. Backpressure: header consumed, wr_ready=0 throughout, send 6 pixel bytes with count=6 -> first byte held in the output register, next 4 in the FIFO, 6th dropped, overflow=1. Then wr_ready=1 -> exactly 5 writes, data unchanged while stalled.
3. Address wrap: SET_ADDRESS 3F FF FF; WRITE_PIXELS count 2, pixels 11 22 -> writes (0x3FFFFF,11), (0x000000,22).
4. Fill: SET_ADDRESS 00 01 00; cmd 03, data 00 05 1F; send data byte 44 during the fill -> writes 0x100..0x104 all 0x1F. Then 44 is popped in IDLE, discarded, error=1.
5. Abort and error: WRITE_PIXELS count 4, pixels 01 02, then cmd 01 00 00 10 -> only 2 writes; pointer=0x000010. Cmd 7E -> error=1, no writes.
6. Reset mid-operation: assert reset while wr_valid=1 and the FIFO holds 3 bytes -> wr_valid=0 asynchronously, busy=0, and after release a new SET_ADDRESS/WRITE sequence behaves as in scenario 1.
